// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and bus addresses for the sprite DMA arbiter.
package oam_dma_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dmastate_t;

    localparam logic [15:0] OAM_DMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_arbiter.sv
// Sprite DMA sequencer: passes core bus traffic through in IDLE, otherwise holds
// the core and copies page P ($P00-$PFF) to OAMDATA on alternating get/put cycles.
//
// state | meaning
// IDLE  | core owns the bus, $4014 writes swallowed and arm a DMA
// HALT  | first stalled cycle, no strobes
// ALIGN | extra dummy cycle so READ lands on a get cycle
// READ  | get cycle: read {page,idx}, latch data
// WRITE | put cycle: write latched byte to OAMDATA, advance idx
module oam_dma_arbiter #(
    parameter logic [15:0] DMA_REG_ADDR  = oam_dma_arbiter_pkg::OAM_DMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = oam_dma_arbiter_pkg::OAM_DATA_ADDR,
    parameter int          XFER_LEN      = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdy,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy
);
    import oam_dma_arbiter_pkg::*;

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dmastate_t  state, state_nxt;
    logic       put;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_latch;
    logic       dma_reg_hit;

    assign dma_reg_hit = (cpu_addr == DMA_REG_ADDR);
    assign cpu_rdata   = bus_rdata;
    assign dma_busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            put        <= 1'b0;
            page       <= 8'h00;
            idx        <= 8'h00;
            data_latch <= 8'h00;
        end else if (cpu_ce) begin
            state <= state_nxt;
            put   <= ~put;
            case (state)
                IDLE: begin
                    if (cpu_we && dma_reg_hit) begin
                        page <= cpu_wdata;
                        idx  <= 8'h00;
                    end
                end
                READ:    data_latch <= bus_rdata;
                WRITE:   idx        <= idx + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        bus_addr  = {page, idx};
        bus_wdata = data_latch;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        cpu_rdy   = 1'b0;
        case (state)
            IDLE: begin
                cpu_rdy   = 1'b1;
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_we    = cpu_we && !dma_reg_hit;
                bus_re    = cpu_re;
                if (cpu_we && dma_reg_hit)
                    state_nxt = HALT;
            end
            // HALT's own parity decides whether one extra cycle is needed before READ
            HALT:  state_nxt = put ? READ : ALIGN;
            ALIGN: state_nxt = READ;
            READ: begin
                bus_re    = cpu_ce;
                state_nxt = WRITE;
            end
            WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_we    = cpu_ce;
                state_nxt = (idx == LAST_IDX) ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
